load_store_unit: RTL and testbench

//  Initiator side of the data-memory interface: accepts one load/store request from the MEM stage over a

---
 rtl/load_store_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface. Accepts one
// request at a time, rejects illegal, out-of-range or misaligned requests
// before any memory access, zero-extends unsigned loads, and keeps
// saturating load/store/fault statistics.
module load_store_unit #(
    parameter int ADDR_LIMIT = 4096,
    parameter int COUNT_W    = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               ReqValid,
    output logic               ReqReady,
    input  logic [3:0]         ReqOp,
    input  logic [31:0]        ReqAddr,
    input  logic [31:0]        ReqData,
    output logic               RespValid,
    input  logic               RespReady,
    output logic [31:0]        RespData,
    output logic               RespFault,
    output logic [1:0]         RespFaultCode,
    output logic [31:0]        Address,
    output logic [31:0]        WriteData,
    output logic [1:0]         MemWrite,
    output logic [1:0]         MemRead,
    input  logic [31:0]        MemReadData,
    output logic [COUNT_W-1:0] LoadCount,
    output logic [COUNT_W-1:0] StoreCount,
    output logic [COUNT_W-1:0] FaultCount
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [31:0]        LIMIT   = 32'(ADDR_LIMIT);
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [1:0]         mem_write_q, mem_write_d;
    logic [1:0]         mem_read_q, mem_read_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_fault_q, resp_fault_d;
    logic [1:0]         resp_code_q, resp_code_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [COUNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [COUNT_W-1:0] store_cnt_q, store_cnt_d;
    logic [COUNT_W-1:0] fault_cnt_q, fault_cnt_d;

    logic               req_is_load;
    logic               req_is_store;
    logic [1:0]         req_size;
    logic               req_misaligned;
    logic [1:0]         req_code;
    logic [31:0]        load_result;

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Decode the incoming opcode into direction and size, and rank the fault checks.
    always_comb begin
        req_is_load  = 1'b0;
        req_is_store = 1'b0;
        req_size     = 2'b00;
        case (ReqOp)
            4'b0000: begin req_is_load  = 1'b1; req_size = 2'b01; end
            4'b0001,
            4'b0010: begin req_is_load  = 1'b1; req_size = 2'b10; end
            4'b0011,
            4'b0100: begin req_is_load  = 1'b1; req_size = 2'b11; end
            4'b1000: begin req_is_store = 1'b1; req_size = 2'b01; end
            4'b1001: begin req_is_store = 1'b1; req_size = 2'b10; end
            4'b1010: begin req_is_store = 1'b1; req_size = 2'b11; end
            default: begin req_size = 2'b00; end
        endcase
        req_misaligned = ((req_size == 2'b01) && (ReqAddr[1:0] != 2'b00)) ||
                         ((req_size == 2'b10) && ReqAddr[0]);
        if (!(req_is_load || req_is_store)) begin
            req_code = 2'b11;
        end else if (ReqAddr >= LIMIT) begin
            req_code = 2'b10;
        end else if (req_misaligned) begin
            req_code = 2'b01;
        end else begin
            req_code = 2'b00;
        end
    end

    // The memory already sign-extends; only unsigned loads need their upper bits cleared.
    always_comb begin
        case (op_q)
            4'b0010: load_result = {16'h0000, MemReadData[15:0]};
            4'b0100: load_result = {24'h000000, MemReadData[7:0]};
            4'b1000,
            4'b1001,
            4'b1010: load_result = 32'h0000_0000;
            default: load_result = MemReadData;
        endcase
    end

    // Next-state and next-output logic for the IDLE -> ACCESS/RESP -> IDLE sequence.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mem_write_d  = mem_write_q;
        mem_read_d   = mem_read_q;
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        resp_code_d  = resp_code_q;
        resp_data_d  = resp_data_q;
        load_cnt_d   = load_cnt_q;
        store_cnt_d  = store_cnt_q;
        fault_cnt_d  = fault_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    op_d = ReqOp;
                    if (req_code != 2'b00) begin
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_code_d  = req_code;
                        resp_data_d  = 32'h0000_0000;
                        fault_cnt_d  = sat_inc(fault_cnt_q);
                        state_d      = ST_RESP;
                    end else begin
                        addr_d  = ReqAddr;
                        wdata_d = ReqData;
                        if (req_is_store) begin
                            mem_write_d = req_size;
                        end else begin
                            mem_read_d = req_size;
                        end
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                mem_write_d  = 2'b00;
                mem_read_d   = 2'b00;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_code_d  = 2'b00;
                resp_data_d  = load_result;
                if (op_q[3]) begin
                    store_cnt_d = sat_inc(store_cnt_q);
                end else begin
                    load_cnt_d = sat_inc(load_cnt_q);
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (RespReady) begin
                    resp_valid_d = 1'b0;
                    resp_fault_d = 1'b0;
                    resp_code_d  = 2'b00;
                    resp_data_d  = 32'h0000_0000;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state, including the memory strobes, clears the instant reset rises.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            op_q         <= 4'h0;
            addr_q       <= 32'h0000_0000;
            wdata_q      <= 32'h0000_0000;
            mem_write_q  <= 2'b00;
            mem_read_q   <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_code_q  <= 2'b00;
            resp_data_q  <= 32'h0000_0000;
            load_cnt_q   <= '0;
            store_cnt_q  <= '0;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mem_write_q  <= mem_write_d;
            mem_read_q   <= mem_read_d;
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
            resp_code_q  <= resp_code_d;
            resp_data_q  <= resp_data_d;
            load_cnt_q   <= load_cnt_d;
            store_cnt_q  <= store_cnt_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign ReqReady      = (state_q == ST_IDLE);
    assign RespValid     = resp_valid_q;
    assign RespData      = resp_data_q;
    assign RespFault     = resp_fault_q;
    assign RespFaultCode = resp_code_q;
    assign Address       = addr_q;
    assign WriteData     = wdata_q;
    assign MemWrite      = mem_write_q;
    assign MemRead       = mem_read_q;
    assign LoadCount     = load_cnt_q;
    assign StoreCount    = store_cnt_q;
    assign FaultCount    = fault_cnt_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a byte-array data memory on the memory side,
// a request-level reference model, directed scenarios and a randomized run.
module tb_load_store_unit;

    localparam int ADDR_LIMIT = 4096;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        ReqValid = 1'b0;
    logic [3:0]  ReqOp = 4'h0;
    logic [31:0] ReqAddr = 32'h0;
    logic [31:0] ReqData = 32'h0;
    logic        RespReady = 1'b0;
    logic [31:0] memReadData = 32'h0;

    logic        ReqReady, RespValid, RespFault;
    logic [1:0]  RespFaultCode, MemWrite, MemRead;
    logic [31:0] RespData, Address, WriteData;
    logic [15:0] LoadCount, StoreCount, FaultCount;

    logic        sReqReady, sRespValid, sRespFault;
    logic [1:0]  sRespFaultCode, sMemWrite, sMemRead;
    logic [31:0] sRespData, sAddress, sWriteData;
    logic [1:0]  sLoadCount, sStoreCount, sFaultCount;

    logic [7:0]  memBytes [0:4095];
    logic [7:0]  refBytes [0:4095];
    int          memWriteCycles = 0;
    int          loadCnt = 0;
    int          storeCnt = 0;
    int          faultCnt = 0;
    int          compareCount = 0;
    int          mismatchCount = 0;
    logic [3:0]  legalOps [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA};

    always #5 Clk = ~Clk;

    load_store_unit #(.ADDR_LIMIT(ADDR_LIMIT), .COUNT_W(16)) u_dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
        .RespFault(RespFault), .RespFaultCode(RespFaultCode),
        .Address(Address), .WriteData(WriteData), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemReadData(memReadData),
        .LoadCount(LoadCount), .StoreCount(StoreCount), .FaultCount(FaultCount)
    );

    // Narrow-counter twin fed the same stimulus; only its counters are observed.
    load_store_unit #(.ADDR_LIMIT(ADDR_LIMIT), .COUNT_W(2)) u_small (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(sReqReady),
        .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .RespValid(sRespValid), .RespReady(RespReady), .RespData(sRespData),
        .RespFault(sRespFault), .RespFaultCode(sRespFaultCode),
        .Address(sAddress), .WriteData(sWriteData), .MemWrite(sMemWrite),
        .MemRead(sMemRead), .MemReadData(memReadData),
        .LoadCount(sLoadCount), .StoreCount(sStoreCount), .FaultCount(sFaultCount)
    );

    // Data memory: commits stores on the rising edge, little-endian.
    always @(posedge Clk) begin : memWritePort
        int base;
        base = int'(Address[11:0]);
        if (MemWrite != 2'b00) begin
            memWriteCycles++;
            case (MemWrite)
                2'b01: begin
                    memBytes[base & ~3]     = WriteData[7:0];
                    memBytes[(base & ~3)+1] = WriteData[15:8];
                    memBytes[(base & ~3)+2] = WriteData[23:16];
                    memBytes[(base & ~3)+3] = WriteData[31:24];
                end
                2'b10: begin
                    memBytes[base & ~1]     = WriteData[7:0];
                    memBytes[(base & ~1)+1] = WriteData[15:8];
                end
                default: memBytes[base] = WriteData[7:0];
            endcase
        end
    end

    // Data memory: presents sign-extended read data on the falling edge.
    always @(negedge Clk) begin : memReadPort
        int base;
        base = int'(Address[11:0]);
        case (MemRead)
            2'b01: memReadData <= {memBytes[(base & ~3)+3], memBytes[(base & ~3)+2],
                                   memBytes[(base & ~3)+1], memBytes[base & ~3]};
            2'b10: memReadData <= {{16{memBytes[(base & ~1)+1][7]}},
                                   memBytes[(base & ~1)+1], memBytes[base & ~1]};
            2'b11: memReadData <= {{24{memBytes[base][7]}}, memBytes[base]};
            default: ;
        endcase
    end

    function automatic int satTo(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic bit isLegal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA};
    endfunction

    function automatic bit isStoreOp(input logic [3:0] op);
        return op inside {4'h8, 4'h9, 4'hA};
    endfunction

    function automatic int refSize(input logic [3:0] op);
        if (op == 4'h0 || op == 4'h8) return 4;
        if (op == 4'h1 || op == 4'h2 || op == 4'h9) return 2;
        return 1;
    endfunction

    function automatic logic [1:0] sizeCode(input logic [3:0] op);
        case (refSize(op))
            4: return 2'b01;
            2: return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [1:0] refCode(input logic [3:0] op, input logic [31:0] addr);
        if (!isLegal(op)) return 2'b11;
        if (addr >= 32'(ADDR_LIMIT)) return 2'b10;
        if ((addr % 32'(refSize(op))) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] refLoad(input logic [3:0] op, input logic [31:0] addr);
        int a;
        logic [31:0] w;
        a = int'(addr[11:0]);
        case (op)
            4'h0: w = {refBytes[a+3], refBytes[a+2], refBytes[a+1], refBytes[a]};
            4'h1: begin
                w = 32'({refBytes[a+1], refBytes[a]});
                if (w >= 32'd32768) w = w + 32'hFFFF_0000;
            end
            4'h2: w = 32'({refBytes[a+1], refBytes[a]});
            4'h3: begin
                w = 32'(refBytes[a]);
                if (w >= 32'd128) w = w + 32'hFFFF_FF00;
            end
            default: w = 32'(refBytes[a]);
        endcase
        return w;
    endfunction

    task automatic refStore(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
        int a;
        a = int'(addr[11:0]);
        for (int k = 0; k < refSize(op); k++) begin
            refBytes[a+k] = 8'((data >> (8*k)) & 32'hFF);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkCounters();
        checkOutput("load_count", 32'(LoadCount), 32'(satTo(loadCnt, 65535)));
        checkOutput("store_count", 32'(StoreCount), 32'(satTo(storeCnt, 65535)));
        checkOutput("fault_count", 32'(FaultCount), 32'(satTo(faultCnt, 65535)));
        checkOutput("small_load_count", 32'(sLoadCount), 32'(satTo(loadCnt, 3)));
        checkOutput("small_store_count", 32'(sStoreCount), 32'(satTo(storeCnt, 3)));
        checkOutput("small_fault_count", 32'(sFaultCount), 32'(satTo(faultCnt, 3)));
    endtask

    // One full request/response; called #1 after a rising edge with the unit idle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] data, input int hold,
                                 output logic [31:0] respSeen);
        logic [1:0]  code;
        logic [31:0] expData;
        bit          st;
        int          wBefore;
        code = refCode(op, addr);
        st = isStoreOp(op);
        checkOutput("req_ready_idle", 32'(ReqReady), 32'd1);
        ReqValid = 1'b1; ReqOp = op; ReqAddr = addr; ReqData = data;
        wBefore = memWriteCycles;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        if (code != 2'b00) begin
            faultCnt++;
            expData = 32'h0;
        end else begin
            checkOutput("access_memwrite", 32'(MemWrite), 32'(st ? sizeCode(op) : 2'b00));
            checkOutput("access_memread", 32'(MemRead), 32'(st ? 2'b00 : sizeCode(op)));
            checkOutput("access_address", Address, addr);
            if (st) checkOutput("access_wdata", WriteData, data);
            checkOutput("access_resp_valid", 32'(RespValid), 32'd0);
            checkOutput("access_req_ready", 32'(ReqReady), 32'd0);
            if (st) begin
                expData = 32'h0;
                refStore(op, addr, data);
                storeCnt++;
            end else begin
                expData = refLoad(op, addr);
                loadCnt++;
            end
            @(posedge Clk); #1;
        end
        checkOutput("resp_valid", 32'(RespValid), 32'd1);
        checkOutput("resp_fault", 32'(RespFault), 32'(code != 2'b00));
        checkOutput("resp_code", 32'(RespFaultCode), 32'(code));
        checkOutput("resp_data", RespData, expData);
        checkOutput("resp_memwrite", 32'(MemWrite), 32'd0);
        checkOutput("resp_memread", 32'(MemRead), 32'd0);
        checkOutput("resp_req_ready", 32'(ReqReady), 32'd0);
        respSeen = RespData;
        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'b1;
            ReqOp = legalOps[$urandom_range(0, 7)];
            ReqAddr = 32'($urandom_range(0, 255)) & ~32'h3;
            @(posedge Clk); #1;
            checkOutput("hold_resp_valid", 32'(RespValid), 32'd1);
            checkOutput("hold_resp_data", RespData, expData);
            checkOutput("hold_req_ready", 32'(ReqReady), 32'd0);
            checkOutput("hold_mem_idle", 32'({MemWrite, MemRead}), 32'd0);
        end
        ReqValid = 1'b0;
        RespReady = 1'b1;
        @(posedge Clk); #1;
        RespReady = 1'b0;
        checkOutput("done_resp_valid", 32'(RespValid), 32'd0);
        checkOutput("done_resp_data", RespData, 32'h0);
        checkOutput("done_resp_fault", 32'({RespFault, RespFaultCode}), 32'd0);
        checkOutput("done_req_ready", 32'(ReqReady), 32'd1);
        checkOutput("mem_write_cycles", 32'(memWriteCycles - wBefore),
                    32'((code == 2'b00 && st) ? 1 : 0));
        checkCounters();
    endtask

    // Reset arrives asynchronously in the middle of a byte store's access cycle.
    task automatic resetMidAccess();
        logic [7:0] oldByte;
        oldByte = refBytes[12'h30];
        checkOutput("rst_pre_ready", 32'(ReqReady), 32'd1);
        ReqValid = 1'b1; ReqOp = 4'hA; ReqAddr = 32'h30; ReqData = {24'h0, ~oldByte};
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        checkOutput("rst_access_memwrite", 32'(MemWrite), 32'd3);
        #2;
        Rst = 1'b1;
        #1;
        checkOutput("rst_memwrite_now", 32'(MemWrite), 32'd0);
        checkOutput("rst_resp_valid", 32'(RespValid), 32'd0);
        checkOutput("rst_req_ready", 32'(ReqReady), 32'd1);
        loadCnt = 0; storeCnt = 0; faultCnt = 0;
        @(posedge Clk); #1;
        checkOutput("rst_mem_byte", 32'(memBytes[12'h30]), 32'(oldByte));
        checkCounters();
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  op;
        logic [31:0] addr;
        int          diffs;
        for (int i = 0; i < 4096; i++) begin
            refBytes[i] = 8'($urandom_range(0, 255));
            memBytes[i] = refBytes[i];
        end

        #1 Rst = 1'b1;
        #1;
        checkOutput("reset_req_ready", 32'(ReqReady), 32'd1);
        checkOutput("reset_resp", 32'({RespValid, RespFault, RespFaultCode}), 32'd0);
        checkOutput("reset_mem", 32'({MemWrite, MemRead}), 32'd0);
        checkOutput("reset_address", Address, 32'h0);
        checkCounters();
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;

        applyStimulus(4'h8, 32'h10, 32'h1234_5678, 0, r);
        applyStimulus(4'h0, 32'h10, 32'h0, 0, r);
        checkOutput("dir_lw_data", r, 32'h1234_5678);
        checkOutput("dir_counts", 32'({LoadCount, StoreCount}), 32'h0001_0001);

        applyStimulus(4'h8, 32'h20, 32'h80FF_7F01, 0, r);
        applyStimulus(4'h3, 32'h22, 32'h0, 0, r);
        checkOutput("dir_lb", r, 32'hFFFF_FFFF);
        applyStimulus(4'h4, 32'h23, 32'h0, 0, r);
        checkOutput("dir_lbu", r, 32'h0000_0080);
        applyStimulus(4'h1, 32'h20, 32'h0, 0, r);
        checkOutput("dir_lh", r, 32'h0000_7F01);
        applyStimulus(4'h2, 32'h22, 32'h0, 0, r);
        checkOutput("dir_lhu", r, 32'h0000_80FF);

        applyStimulus(4'h0, 32'h06, 32'h0, 0, r);
        checkOutput("dir_misaligned_code", 32'(RespFaultCode), 32'd0);
        applyStimulus(4'h9, 32'h1001, 32'hBEEF, 0, r);
        applyStimulus(4'h7, 32'h40, 32'h0, 0, r);
        checkOutput("dir_fault_count", 32'(FaultCount), 32'd3);

        applyStimulus(4'h0, 32'h20, 32'h0, 5, r);
        checkOutput("dir_hold_data", r, 32'h80FF_7F01);

        resetMidAccess();

        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'hA, 32'(64 + i), 32'(i), 0, r);
        end
        checkOutput("dir_small_store_sat", 32'(sStoreCount), 32'd3);
        checkOutput("dir_store_count_5", 32'(StoreCount), 32'd5);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(0, 15));
            else op = legalOps[$urandom_range(0, 7)];
            if ($urandom_range(0, 9) == 0) begin
                addr = 32'h1000 + 32'($urandom_range(0, 65535));
            end else begin
                addr = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) addr = addr & ~32'(refSize(op) - 1);
            end
            applyStimulus(op, addr, $urandom, $urandom_range(0, 2), r);
        end

        diffs = 0;
        for (int i = 0; i < 4096; i++) begin
            if (memBytes[i] !== refBytes[i]) diffs++;
        end
        checkOutput("mem_image_diffs", 32'(diffs), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
